stream_decompress_nucleotides: RTL and testbench
================================================

# stream_decompress_nucleotides

Streaming, parametrised successor to the flat packed-to-ASCII nucleotide decoder: accepts one 2-bit-packed read (A=00, C=01, G=10, T=11) plus its true length over a valid/ready handshake. It emits the ASCII string over several output beats of `BASES_PER_BEAT` characters each, with byte-enable and last flags. An optional reverse-complement mode is selected per read. It sits between read storage/DMA and host-bound string output, so downstream logic never needs a full `8*LENGTH`-bit bus.

## Interface
Parameters:
- `LENGTH`, 256: maximum bases per read.
- `BASES_PER_BEAT`, 16: ASCII characters per output beat; 1 ≤ `BASES_PER_BEAT` ≤ `LENGTH`.
- `LEN_W`, `$clog2(LENGTH+1)`: width of length field.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rstb` in 1: asynchronous, active-low reset.
- `in_valid` in 1: read offered.
- `in_ready` out 1: read accepted when `in_valid && in_ready`.
- `in_read` in `2*LENGTH`: packed read, base i at bits `[2i+1:2i]`.
- `in_len` in `LEN_W`: number of valid bases; values > `LENGTH` clamp to `LENGTH`.
- `in_revcomp` in 1: 1 = emit reverse complement.
- `out_valid` out 1: beat present.
- `out_ready` in 1: beat consumed when `out_valid && out_ready`.
- `out_data` out `8*BASES_PER_BEAT`: characters, byte k at bits `[8k+7:8k]`, byte 0 first in string order.
- `out_keep` out `BASES_PER_BEAT`: bit k = byte k valid.
- `out_last` out 1: final beat of the read.

## Operation
- States: IDLE, EMIT.
- IDLE: `in_ready`=1, `out_valid`=0. On accept, capture `in_read`, the clamped length `len`, and `in_revcomp` into registers; clear the beat pointer `ptr`=0; go to EMIT.
- EMIT: `out_valid`=1. Byte k of the current beat is string position p = `ptr*BASES_PER_BEAT + k`.
  - Forward: source base index = p, code unchanged.
  - Revcomp: source base index = `len-1-p`, code XOR 2'b11 (A↔T, C↔G).
  - p < `len`: `keep[k]`=1, byte = ASCII of the code (A=65, C=67, G=71, T=84).
  - p ≥ `len`: `keep[k]`=0, byte = 8'h00.
- `out_last` = 1 when `(ptr+1)*BASES_PER_BEAT ≥ len`.
- On a beat handshake without last: `ptr` increments and the FSM stays in EMIT.
- On a handshake with last: if `in_valid` is high in the same cycle, the new read is captured (`in_ready`=1 in this cycle) and the FSM stays in EMIT with `ptr`=0. Otherwise the FSM returns to IDLE.
- In EMIT, `in_ready` = `out_ready && out_last`.
- `len`=0: exactly one beat, `out_keep`=0, `out_data`=0, `out_last`=1.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_keep` and `out_last` hold stable.
- Reset (asserted at any time, including mid-read): state = IDLE, `ptr`=0, read/len/mode registers = 0, `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `in_ready`=1. Any partial read is discarded, with no further beats for it.

## Timing
- Latency: read accepted at edge t → first beat `out_valid` from t (visible the cycle after the accept cycle).
- Throughput: one beat per cycle while `out_ready`=1. Back-to-back reads have zero bubble cycles.
- Beats per read = `max(1, ceil(len/BASES_PER_BEAT))`.
- `out_*` are functions of registered state only; there is no combinational path from `in_*` to `out_*`.
- `in_ready` has a combinational path from `out_ready`.
- Byte mux: index arithmetic uses `LEN_W`+1 bits so `len-1-p` never wraps for valid bytes.

## Structure
- `nucleotide_pkg` holds:
  - 2-bit base encoding constants `BASE_A`/`BASE_C`/`BASE_G`/`BASE_T`.
  - ASCII constants `ASCII_A`=65, `ASCII_C`=67, `ASCII_G`=71, `ASCII_T`=84.
  - Function `complement_base` (XOR 2'b11).
  - FSM state typedef.
- Sub-module `nucleotide_to_ascii`: 2-bit code in, 8-bit ASCII out, purely combinational. Instantiated `BASES_PER_BEAT` times in a generate loop.

## Test plan
- LENGTH=8, BPB=4, read ACGTTGCA (codes 00,01,10,11,11,10,01,00), len=8, forward, `out_ready`=1: two beats.
  - Beat 1: "ACGT", keep=4'hF, last=0.
  - Beat 2: "TGCA", keep=4'hF, last=1.
- Same read, `in_revcomp`=1: beat 1 = "TGCA", beat 2 = "ACGT" (revcomp of ACGTTGCA is TGCAACGT).
- len=5, forward: beat 1 = "ACGT", keep=4'hF; beat 2 byte 0 = "T", keep=4'b0001, bytes 1-3 = 0, last=1.
- len=0: single beat, keep=0, data=0, last=1. `in_len`=12 with LENGTH=8 clamps to 8 and gives exactly 2 beats.
- Backpressure: `out_ready` toggles 1,0,0,1 → beat outputs hold stable during the stall cycles. A second read presented during the last beat is accepted on that beat's handshake, and its first beat follows on the next cycle with no idle gap.
- Assert `rstb`=0 mid-read after beat 1 → `out_valid`=0 and `in_ready`=1 immediately. After release, a new read emits from `ptr`=0 with no remnant of the old read.

Source files
------------

// File: rtl/nucleotide_pkg.sv
// Shared definitions for the nucleotide decompression stream: 2-bit base
// codes, their ASCII characters, complement helper and the FSM state type.
package nucleotide_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    localparam logic [7:0] ASCII_A = 8'd65;
    localparam logic [7:0] ASCII_C = 8'd67;
    localparam logic [7:0] ASCII_G = 8'd71;
    localparam logic [7:0] ASCII_T = 8'd84;

    // Watson-Crick complement: the 2-bit encoding makes A<->T and C<->G a bit flip.
    function automatic logic [1:0] complement_base(input logic [1:0] base);
        return base ^ 2'b11;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/nucleotide_to_ascii.sv
// Combinational translation of one 2-bit base code into its ASCII letter.
module nucleotide_to_ascii
    import nucleotide_pkg::*;
(
    input  logic [1:0] code,
    output logic [7:0] ascii
);

    // Direct lookup of the four base letters.
    always_comb begin
        ascii = ASCII_A;
        case (code)
            BASE_A:  ascii = ASCII_A;
            BASE_C:  ascii = ASCII_C;
            BASE_G:  ascii = ASCII_G;
            BASE_T:  ascii = ASCII_T;
            default: ascii = ASCII_A;
        endcase
    end

endmodule

// File: rtl/stream_decompress_nucleotides.sv
// Accepts one packed 2-bit read and streams it out as ASCII, BASES_PER_BEAT
// characters per beat, optionally reverse-complemented.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and a beat presented with
// out_ready low holds data/keep/last unchanged until it is taken.
module stream_decompress_nucleotides
    import nucleotide_pkg::*;
#(
    parameter int LENGTH         = 256,
    parameter int BASES_PER_BEAT = 16,
    parameter int LEN_W          = $clog2(LENGTH + 1)
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*LENGTH-1:0]         in_read,
    input  logic [LEN_W-1:0]            in_len,
    input  logic                        in_revcomp,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*BASES_PER_BEAT-1:0] out_data,
    output logic [BASES_PER_BEAT-1:0]   out_keep,
    output logic                        out_last
);

    // One extra bit so position and len-1-pos arithmetic never wraps.
    localparam int IW  = LEN_W + 1;
    // Base table padded to the full index range so any index is in bounds.
    localparam int TAB = 2 ** IW;

    state_t              state;
    logic [2*LENGTH-1:0] read_q;
    logic [LEN_W-1:0]    len_q;
    logic                rc_q;
    logic [LEN_W-1:0]    ptr;

    logic                emitting;
    logic [LEN_W-1:0]    len_clamp;
    logic [IW-1:0]       beat_end;
    logic [1:0]          bases [TAB];

    assign emitting = (state == ST_EMIT);

    // Lengths beyond the read capacity are treated as a full read.
    always_comb begin
        len_clamp = in_len;
        if (in_len > LEN_W'(LENGTH)) begin
            len_clamp = LEN_W'(LENGTH);
        end
    end

    // Last beat once this beat reaches or passes the read length.
    always_comb begin
        beat_end = (IW'(ptr) + IW'(1)) * IW'(BASES_PER_BEAT);
        out_last = emitting && (beat_end >= {1'b0, len_q});
    end

    assign out_valid = emitting;
    assign in_ready  = !emitting || (out_ready && out_last);

    for (genvar i = 0; i < TAB; i++) begin : g_base
        if (i < LENGTH) begin : g_real
            assign bases[i] = read_q[2*i +: 2];
        end else begin : g_pad
            assign bases[i] = BASE_A;
        end
    end

    for (genvar k = 0; k < BASES_PER_BEAT; k++) begin : g_byte
        logic [IW-1:0] pos;
        logic [IW-1:0] src;
        logic          hit;
        logic [1:0]    code;
        logic [7:0]    ascii;

        // Map byte k of the current beat to its source base and code.
        always_comb begin
            pos  = IW'(ptr) * IW'(BASES_PER_BEAT) + IW'(k);
            hit  = emitting && (pos < {1'b0, len_q});
            src  = rc_q ? ({1'b0, len_q} - IW'(1) - pos) : pos;
            code = bases[src];
            if (rc_q) begin
                code = complement_base(code);
            end
        end

        nucleotide_to_ascii u_conv (
            .code  (code),
            .ascii (ascii)
        );

        assign out_keep[k]        = hit;
        assign out_data[8*k +: 8] = hit ? ascii : 8'h00;
    end

    // Read capture, beat pointer advance and IDLE/EMIT sequencing.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= ST_IDLE;
            read_q <= '0;
            len_q  <= '0;
            rc_q   <= 1'b0;
            ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        read_q <= in_read;
                        len_q  <= len_clamp;
                        rc_q   <= in_revcomp;
                        ptr    <= '0;
                        state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            if (in_valid) begin
                                read_q <= in_read;
                                len_q  <= len_clamp;
                                rc_q   <= in_revcomp;
                                ptr    <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            ptr <= ptr + LEN_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_decompress_nucleotides.sv
// Bench for stream_decompress_nucleotides with LENGTH=8, BASES_PER_BEAT=4.
module tb_stream_decompress_nucleotides;

    localparam int LENGTH = 8;
    localparam int BPB    = 4;
    localparam int LEN_W  = 4;
    localparam int BW     = 8*BPB + BPB + 1;

    logic                clk;
    logic                rstb;
    logic                in_valid;
    logic                in_ready;
    logic [2*LENGTH-1:0] in_read;
    logic [LEN_W-1:0]    in_len;
    logic                in_revcomp;
    logic                out_valid;
    logic                out_ready;
    logic [8*BPB-1:0]    out_data;
    logic [BPB-1:0]      out_keep;
    logic                out_last;

    int total = 0;
    int bad   = 0;
    bit rand_rdy = 0;

    logic [BW-1:0] exp_q[$];
    byte unsigned  lut[4] = '{8'd65, 8'd67, 8'd71, 8'd84};

    stream_decompress_nucleotides #(
        .LENGTH         (LENGTH),
        .BASES_PER_BEAT (BPB),
        .LEN_W          (LEN_W)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_read    (in_read),
        .in_len     (in_len),
        .in_revcomp (in_revcomp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: build the string, then cut it into beats.
    task automatic push_model(input logic [2*LENGTH-1:0] rd, input int ln, input bit rc);
        int len;
        int beats;
        int code;
        int pos;
        logic [8*BPB-1:0] d;
        logic [BPB-1:0]   kp;
        byte unsigned     str[$];
        len = (ln > LENGTH) ? LENGTH : ln;
        for (int i = 0; i < len; i++) begin
            if (rc) code = 3 - int'(rd[2*(len-1-i) +: 2]);
            else    code = int'(rd[2*i +: 2]);
            str.push_back(lut[code]);
        end
        beats = (len == 0) ? 1 : (len + BPB - 1) / BPB;
        for (int b = 0; b < beats; b++) begin
            d  = '0;
            kp = '0;
            for (int k = 0; k < BPB; k++) begin
                pos = b*BPB + k;
                if (pos < len) begin
                    d[8*k +: 8] = str[pos];
                    kp[k] = 1'b1;
                end
            end
            exp_q.push_back({(b == beats-1), kp, d});
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a read and hold it until accepted.
    task automatic send(input logic [2*LENGTH-1:0] rd, input int ln, input bit rc);
        int cyc;
        bit acc;
        in_read    = rd;
        in_len     = LEN_W'(ln);
        in_revcomp = rc;
        in_valid   = 1'b1;
        push_model(rd, ln, rc);
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 300) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("accept", 64'(acc), 64'd1);
    endtask

    // Let all expected beats drain.
    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 600) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: compare each consumed beat and check stalls hold stable.
    logic          stall_pending = 1'b0;
    logic [BW-1:0] held;
    always @(negedge clk) begin
        logic [BW-1:0] cur;
        logic [BW-1:0] e;
        cur = {out_last, out_keep, out_data};
        if (!rstb || !out_valid) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) check("stall_hold", 64'(cur), 64'(held));
            if (!out_ready) begin
                stall_pending = 1'b1;
                held = cur;
            end else begin
                stall_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(cur), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
            end
        end
    end

    initial begin
        rstb       = 1'b0;
        in_valid   = 1'b0;
        in_read    = '0;
        in_len     = '0;
        in_revcomp = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // ACGTTGCA forward, full length.
        out_ready = 1'b1;
        send(16'h1BE4, 8, 1'b0);
        check("fwd_b1_data", 64'(out_data), 64'h54474341);
        check("fwd_b1_keep", 64'(out_keep), 64'hF);
        check("fwd_b1_last", 64'(out_last), 64'd0);
        drain();

        // Same read reverse-complemented.
        send(16'h1BE4, 8, 1'b1);
        check("rc_b1_data", 64'(out_data), 64'h41434754);
        drain();

        // Partial length, zero length, clamped length.
        send(16'h1BE4, 5, 1'b0);
        drain();
        send(16'h1BE4, 0, 1'b0);
        check("len0_last", 64'(out_last), 64'd1);
        check("len0_keep", 64'(out_keep), 64'd0);
        drain();
        send(16'hA5C3, 12, 1'b1);
        drain();

        // Backpressure 1,0,0,1 then a back-to-back read on the last beat.
        out_ready = 1'b0;
        send(16'h1BE4, 8, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h3C96, 7, 1'b1);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_queue", 64'(exp_q.size()), 64'd2);
        drain();

        // Randomized reads with random backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(16'($urandom_range(0, 65535)), int'($urandom_range(0, 12)),
                 1'($urandom_range(0, 1)));
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a read.
        send(16'h1BE4, 8, 1'b0);
        @(posedge clk); #1;
        rstb = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_keep", 64'(out_keep), 64'd0);
        check("midrst_out_last", 64'(out_last), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;
        send(16'hE41B, 6, 1'b1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_all", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
